sd_sector_server: RTL and testbench

SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

---
 rtl/sd_srv_pkg.sv | 15 +
 rtl/sd_sector_ram.sv | 37 +++
 rtl/sd_sector_server.sv | 152 +++++++++++++++
 tb/tb_sd_sector_server.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_srv_pkg.sv
// rtl/sd_srv_pkg.sv - shared constants and FSM state type for the SD sector server
package sd_srv_pkg;

    localparam int          WORDS_PER_SECTOR = 256;
    localparam logic [15:0] FILL_WORD        = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        XFER_RD,
        XFER_WR,
        DONE
    } srv_state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// rtl/sd_sector_ram.sv - true dual-port sector RAM, one-cycle registered read on both ports
module sd_sector_ram #(
    parameter int DEPTH = 32768,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_a_addr,
    input  logic          i_a_we,
    input  logic [15:0]   i_a_din,
    output logic [15:0]   o_a_dout,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_we,
    input  logic [15:0]   i_b_din,
    output logic [15:0]   o_b_dout
);

    logic [15:0] r_mem [0:DEPTH-1];
    logic [15:0] r_a_q;
    logic [15:0] r_b_q;

    // Port A is written after port B so the server side wins a same-word collision;
    // both reads return the contents from before this edge.
    always_ff @(posedge i_clk) begin
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_din;
        end
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_din;
        end
        r_a_q <= r_mem[i_a_addr];
        r_b_q <= r_mem[i_b_addr];
    end

    assign o_a_dout = r_a_q;
    assign o_b_dout = r_b_q;

endmodule

// File: rtl/sd_sector_server.sv
// rtl/sd_sector_server.sv - serves 512-byte sectors to an SD-style client from a host-shared RAM
module sd_sector_server
    import sd_srv_pkg::*;
#(
    parameter int SECTORS   = 128,
    parameter int ACK_DELAY = 4,
    localparam int AW = $clog2(SECTORS * WORDS_PER_SECTOR),
    localparam int SW = AW - 8
) (
    input  logic          clk_sys,
    input  logic          RESET_N,
    input  logic [31:0]   sd_lba,
    input  logic          sd_rd,
    input  logic          sd_wr,
    output logic          sd_ack,
    output logic [7:0]    sd_buff_addr,
    output logic [15:0]   sd_buff_dout,
    input  logic [15:0]   sd_buff_din,
    output logic          sd_buff_wr,
    input  logic [AW-1:0] host_addr,
    input  logic          host_we,
    input  logic [15:0]   host_din,
    output logic [15:0]   host_dout,
    output logic          lba_err
);

    srv_state_t  r_state;
    srv_state_t  w_state_nxt;
    logic [7:0]  r_dly;
    logic [8:0]  r_cnt;
    logic [SW-1:0] r_lba;
    logic        r_oob;
    logic        r_dir_wr;
    logic        r_ack;
    logic        r_buff_wr;
    logic [7:0]  r_buff_addr;
    logic [15:0] r_buff_dout;
    logic        r_lba_err;

    logic        w_req;
    logic        w_req_oob;
    logic [7:0]  w_word;
    logic [AW-1:0] w_a_addr;
    logic        w_a_we;
    logic [15:0] w_a_q;

    assign w_req     = sd_rd | sd_wr;
    assign w_req_oob = (sd_lba >= 32'(SECTORS));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = DELAY;
            DELAY:   if (r_dly == 8'(ACK_DELAY - 1)) w_state_nxt = r_dir_wr ? XFER_WR : XFER_RD;
            XFER_RD: if (r_cnt == 9'(WORDS_PER_SECTOR - 1)) w_state_nxt = DONE;
            XFER_WR: if (r_cnt == 9'(WORDS_PER_SECTOR)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reads run one word ahead so word i is in the RAM output register when it is
    // presented; writes lag one word because din arrives a cycle after its address.
    always_comb begin
        w_word = 8'd0;
        if (r_state == XFER_RD) begin
            w_word = r_cnt[7:0] + 8'd1;
        end else if (r_state == XFER_WR) begin
            w_word = r_cnt[7:0] - 8'd1;
        end
    end

    assign w_a_addr = {r_lba, w_word};
    assign w_a_we   = (r_state == XFER_WR) && (r_cnt != 9'd0) && !r_oob;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_dly       <= 8'd0;
            r_cnt       <= 9'd0;
            r_lba       <= '0;
            r_oob       <= 1'b0;
            r_dir_wr    <= 1'b0;
            r_ack       <= 1'b0;
            r_buff_wr   <= 1'b0;
            r_buff_addr <= 8'd0;
            r_buff_dout <= 16'd0;
            r_lba_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lba_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_lba     <= sd_lba[SW-1:0];
                        r_oob     <= w_req_oob;
                        r_lba_err <= w_req_oob;
                        r_dir_wr  <= !sd_rd;
                        r_dly     <= 8'd0;
                    end
                end
                DELAY: begin
                    r_dly <= r_dly + 8'd1;
                    r_cnt <= 9'd0;
                    if (w_state_nxt != DELAY) begin
                        r_ack       <= 1'b1;
                        r_buff_addr <= 8'd0;
                    end
                end
                XFER_RD: begin
                    r_buff_wr   <= 1'b1;
                    r_buff_addr <= r_cnt[7:0];
                    r_buff_dout <= r_oob ? FILL_WORD : w_a_q;
                    r_cnt       <= r_cnt + 9'd1;
                end
                XFER_WR: begin
                    r_cnt <= r_cnt + 9'd1;
                    if (r_cnt < 9'(WORDS_PER_SECTOR - 1)) begin
                        r_buff_addr <= r_cnt[7:0] + 8'd1;
                    end
                end
                DONE: begin
                    r_ack     <= 1'b0;
                    r_buff_wr <= 1'b0;
                end
                default: r_ack <= 1'b0;
            endcase
        end
    end

    sd_sector_ram #(
        .DEPTH (SECTORS * WORDS_PER_SECTOR),
        .AW    (AW)
    ) u_ram (
        .i_clk    (clk_sys),
        .i_a_addr (w_a_addr),
        .i_a_we   (w_a_we),
        .i_a_din  (sd_buff_din),
        .o_a_dout (w_a_q),
        .i_b_addr (host_addr),
        .i_b_we   (host_we),
        .i_b_din  (host_din),
        .o_b_dout (host_dout)
    );

    assign sd_ack       = r_ack;
    assign sd_buff_wr   = r_buff_wr;
    assign sd_buff_addr = r_buff_addr;
    assign sd_buff_dout = r_buff_dout;
    assign lba_err      = r_lba_err;

endmodule

// File: tb/tb_sd_sector_server.sv
// tb/tb_sd_sector_server.sv - randomized self-checking bench for sd_sector_server
module tb_sd_sector_server;

    localparam int SECTORS   = 128;
    localparam int ACK_DELAY = 4;
    localparam int AW        = 15;

    logic          clk_sys = 1'b0;
    logic          RESET_N = 1'b0;
    logic [31:0]   sd_lba = '0;
    logic          sd_rd = 1'b0;
    logic          sd_wr = 1'b0;
    logic          sd_ack;
    logic [7:0]    sd_buff_addr;
    logic [15:0]   sd_buff_dout;
    logic [15:0]   sd_buff_din = '0;
    logic          sd_buff_wr;
    logic [AW-1:0] host_addr = '0;
    logic          host_we = 1'b0;
    logic [15:0]   host_din = '0;
    logic [15:0]   host_dout;
    logic          lba_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] model [SECTORS*256];
    logic [15:0] wbuf  [256];

    always #5 clk_sys = ~clk_sys;

    sd_sector_server #(.SECTORS(SECTORS), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys      (clk_sys),
        .RESET_N      (RESET_N),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .host_addr    (host_addr),
        .host_we      (host_we),
        .host_din     (host_din),
        .host_dout    (host_dout),
        .lba_err      (lba_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [15:0] data);
        host_addr = AW'(addr);
        host_din  = data;
        host_we   = 1'b1;
        tick();
        host_we   = 1'b0;
        model[addr] = data;
    endtask

    task automatic verify_sector(input int s, input string tag);
        int errs = 0;
        for (int i = 0; i < 256; i++) begin
            host_addr = AW'(s*256 + i);
            tick();
            if (host_dout !== model[s*256 + i]) errs++;
        end
        check_eq(tag, errs, 0);
    endtask

    task automatic start_req(input int lba, input bit rd, input bit wr);
        int n = 0;
        sd_lba = 32'(lba);
        sd_rd  = rd;
        sd_wr  = wr;
        tick();
        check_eq("lba_err", 32'(lba_err), 32'(lba >= SECTORS));
        while (sd_ack !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (n == 1) check_eq("lba_err_pulse", 32'(lba_err), 32'd0);
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        check_eq("ack_delay", n, ACK_DELAY);
    endtask

    task automatic do_read(input int lba, input bit both, input int reset_at);
        int errs = 0;
        int nwords;
        logic [15:0] exp;
        nwords = (reset_at >= 0) ? reset_at : 256;
        start_req(lba, 1'b1, both);
        for (int i = 0; i < nwords; i++) begin
            tick();
            exp = (lba < SECTORS) ? model[lba*256 + i] : 16'hFFFF;
            if (sd_ack !== 1'b1 || sd_buff_wr !== 1'b1 || sd_buff_addr !== 8'(i) || sd_buff_dout !== exp)
                errs++;
        end
        check_eq("rd_words", errs, 0);
        if (reset_at >= 0) begin
            #2 RESET_N = 1'b0;
            #1;
            check_eq("rst_ack", 32'(sd_ack), 32'd0);
            check_eq("rst_outs", {7'd0, sd_buff_wr, sd_buff_addr, sd_buff_dout}, 32'd0);
            tick();
            RESET_N = 1'b1;
            tick();
        end else begin
            tick();
            check_eq("rd_end", {30'd0, sd_ack, sd_buff_wr}, 32'd0);
        end
    endtask

    task automatic do_write(input int lba, input int coll);
        int errs = 0;
        logic [7:0]  prev;
        logic [15:0] old;
        old = (lba < SECTORS && coll >= 0) ? model[lba*256 + coll] : 16'h0;
        start_req(lba, 1'b0, 1'b1);
        prev = sd_buff_addr;
        if (sd_buff_addr !== 8'd0) errs++;
        for (int k = 1; k <= 257; k++) begin
            tick();
            sd_buff_din = wbuf[prev];
            if (k <= 255 && sd_buff_addr !== 8'(k)) errs++;
            if (sd_buff_wr !== 1'b0 || sd_ack !== 1'b1) errs++;
            prev = sd_buff_addr;
            if (coll >= 0 && lba < SECTORS) begin
                if (k == coll + 1) begin
                    host_addr = AW'(lba*256 + coll);
                    host_din  = 16'hDEAD;
                    host_we   = 1'b1;
                end
                if (k == coll + 2) begin
                    host_we = 1'b0;
                    check_eq("coll_old", host_dout, old);
                end
            end
        end
        check_eq("wr_frame", errs, 0);
        tick();
        check_eq("wr_end", 32'(sd_ack), 32'd0);
        if (lba < SECTORS)
            for (int i = 0; i < 256; i++) model[lba*256 + i] = wbuf[i];
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) wbuf[i] = 16'($urandom);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] hv;
        repeat (3) tick();
        check_eq("rst_ack0", 32'(sd_ack), 32'd0);
        check_eq("rst_bwr0", 32'(sd_buff_wr), 32'd0);
        check_eq("rst_addr0", 32'(sd_buff_addr), 32'd0);
        check_eq("rst_dout0", 32'(sd_buff_dout), 32'd0);
        check_eq("rst_err0", 32'(lba_err), 32'd0);
        RESET_N = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) host_write(3*256 + i, 16'h3000 + 16'(i));
        for (int i = 0; i < 256; i++) host_write(i, 16'($urandom));
        for (int i = 0; i < 256; i++) host_write(4*256 + i, 16'($urandom));
        for (int i = 0; i < 256; i++) host_write(5*256 + i, 16'($urandom));

        do_read(3, 1'b0, -1);

        for (int i = 0; i < 256; i++) wbuf[i] = 16'hA500 + 16'(i);
        do_write(5, -1);
        host_addr = AW'(5*256 + 7);
        tick();
        hv = host_dout;
        check_eq("host_a507", hv, 16'hA507);
        verify_sector(4, "sector4_kept");

        do_read(200, 1'b0, -1);

        fill_random();
        do_write(133, -1);
        verify_sector(5, "oob_wr_discard");

        fill_random();
        do_write(5, int'($urandom_range(10, 240)));
        verify_sector(5, "coll_server_wins");

        do_read(0, 1'b1, -1);
        do_read(0, 1'b0, 100);
        do_read(0, 1'b0, -1);

        for (int s = 0; s < SECTORS; s++) begin
            fill_random();
            do_write(s, -1);
        end
        for (int s = 0; s < SECTORS; s++) verify_sector(s, "chain_sector");

        for (int t = 0; t < 8; t++) begin
            int lba;
            lba = int'($urandom_range(0, 2*SECTORS - 1));
            if ($urandom_range(0, 1) == 1) begin
                do_read(lba, 1'b0, -1);
            end else begin
                fill_random();
                do_write(lba, -1);
            end
        end
        verify_sector(int'($urandom_range(0, SECTORS - 1)), "final_sector");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
